// File: rtl/sequenciador_passos_pkg.sv
// Shared types and constants for the six-motor step sequencer.
// Optional abort input is enabled with SEQUENCIADOR_PASSOS_ABORTA_EN.
package sequenciador_passos_pkg;

    localparam int N_MOTORES = 6;
    localparam int MOTOR_W   = 3;
    localparam logic [MOTOR_W-1:0] MOTOR_MAX = MOTOR_W'(N_MOTORES - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        GIRANDO,
        ASSENTA,
        FIM
    } estado_t;

    function automatic logic [N_MOTORES-1:0] um_quente(input logic [MOTOR_W-1:0] idx);
        um_quente      = '0;
        um_quente[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/sequenciador_passos_contador_periodo.sv
// Free-running step period counter 0..PERIODO-1 with sync clear and enable.
// Flags the last count (fim) and the first half of the period (meio).
module contador_periodo #(
    parameter int PERIODO = 1000,
    parameter int N_PER   = 10
) (
    input  logic             clock,
    input  logic             zera_as_n,
    input  logic             zera_s,
    input  logic             conta,
    output logic [N_PER-1:0] Q,
    output logic             fim,
    output logic             meio
);

    localparam logic [N_PER-1:0] ULTIMO = N_PER'(PERIODO - 1);
    localparam logic [N_PER-1:0] METADE = N_PER'(PERIODO / 2);

    logic [N_PER-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zera_s)
            cnt_d = '0;
        else if (conta)
            cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign Q    = cnt_q;
    assign fim  = (cnt_q == ULTIMO);
    assign meio = (cnt_q < METADE);

endmodule

// File: rtl/sequenciador_passos.sv
// Step pulse sequencer: turns one of six faces 90 or 180 degrees, then settles.
// Define SEQUENCIADOR_PASSOS_ABORTA_EN to add the abortar input.
module sequenciador_passos
    import sequenciador_passos_pkg::*;
#(
    parameter int PERIODO   = 1000,
    parameter int N_PER     = 10,
    parameter int PASSOS_90 = 50,
    parameter int N_PAS     = 7
) (
    input  logic                 clock,
    input  logic                 zera_as_n,
`ifdef SEQUENCIADOR_PASSOS_ABORTA_EN
    input  logic                 abortar,
`endif
    input  logic                 iniciar,
    input  logic [MOTOR_W-1:0]   motor,
    input  logic                 sentido,
    input  logic                 meia_volta,
    output logic [N_MOTORES-1:0] passo,
    output logic [N_MOTORES-1:0] dir,
    output logic                 ocupado,
    output logic                 fim_movimento,
    output logic                 erro
);

    localparam logic [N_PAS-1:0] ALVO_90  = N_PAS'(PASSOS_90);
    localparam logic [N_PAS-1:0] ALVO_180 = ALVO_90 << 1;

    estado_t            estado_q, estado_d;
    logic [MOTOR_W-1:0] motor_q, motor_d;
    logic               sentido_q, sentido_d;
    logic [N_PAS-1:0]   alvo_q, alvo_d;
    logic [N_PAS-1:0]   passos_q, passos_d;
    logic               erro_q, erro_d;

    logic               per_zera, per_conta, per_fim, per_meio;
    logic [N_PER-1:0]   per_cnt_unused;
    logic               aborta;

`ifdef SEQUENCIADOR_PASSOS_ABORTA_EN
    assign aborta = abortar;
`else
    assign aborta = 1'b0;
`endif

    contador_periodo #(
        .PERIODO (PERIODO),
        .N_PER   (N_PER)
    ) u_periodo (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .zera_s    (per_zera),
        .conta     (per_conta),
        .Q         (per_cnt_unused),
        .fim       (per_fim),
        .meio      (per_meio)
    );

    always_comb begin
        estado_d  = estado_q;
        motor_d   = motor_q;
        sentido_d = sentido_q;
        alvo_d    = alvo_q;
        passos_d  = passos_q;
        erro_d    = 1'b0;
        per_zera  = 1'b0;
        per_conta = 1'b0;
        case (estado_q)
            OCIOSO: if (iniciar) begin
                if (motor <= MOTOR_MAX) begin
                    motor_d   = motor;
                    sentido_d = sentido;
                    alvo_d    = meia_volta ? ALVO_180 : ALVO_90;
                    passos_d  = '0;
                    per_zera  = 1'b1;
                    estado_d  = GIRANDO;
                end else begin
                    erro_d = 1'b1;
                end
            end
            GIRANDO: begin
                per_conta = 1'b1;
                if (aborta) begin
                    per_zera = 1'b1;
                    estado_d = ASSENTA;
                end else if (per_fim) begin
                    // The counter wraps to 0 on this edge, so ASSENTA starts a fresh period.
                    passos_d = passos_q + 1'b1;
                    if (passos_d == alvo_q) estado_d = ASSENTA;
                end
            end
            ASSENTA: begin
                per_conta = 1'b1;
                if (per_fim) estado_d = FIM;
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_q  <= OCIOSO;
            motor_q   <= '0;
            sentido_q <= 1'b0;
            alvo_q    <= '0;
            passos_q  <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            motor_q   <= motor_d;
            sentido_q <= sentido_d;
            alvo_q    <= alvo_d;
            passos_q  <= passos_d;
            erro_q    <= erro_d;
        end
    end

    assign passo         = (estado_q == GIRANDO && per_meio) ? um_quente(motor_q) : '0;
    assign dir           = (estado_q != OCIOSO && sentido_q) ? um_quente(motor_q) : '0;
    assign ocupado       = (estado_q != OCIOSO);
    assign fim_movimento = (estado_q == FIM);
    assign erro          = erro_q;

endmodule
